// File: rtl/h14rx_period_tracker.sv
// rtl/h14rx_period_tracker.sv - HDMI 1.4 sink TMDS period classifier and data-island packet framer
// Defining H14RX_PERIOD_STATS_EN adds saturating err_count/packet_count outputs and the stats_clr input.
package h14rx_pkg;
  typedef enum logic [2:0] {
    Control            = 3'd0,
    VideoPreamble      = 3'd1,
    DataIslandPreamble = 3'd2,
    VideoGuard         = 3'd3,
    DataIslandGuard    = 3'd4,
    VideoActive        = 3'd5,
    DataIslandActive   = 3'd6
  } period_t;
endpackage

module h14rx_period_tracker #(
  parameter int MinPreamble = 8,
  parameter int MaxPackets  = 18
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef H14RX_PERIOD_STATS_EN
  input  logic               stats_clr,
  output logic [15:0]        err_count,
  output logic [15:0]        packet_count,
`endif
  input  logic [2:0][9:0]    tmds,
  output logic [2:0][9:0]    tmds_q,
  output h14rx_pkg::period_t period,
  output logic               packet_start,
  output logic [4:0]         packet_idx,
  output logic [4:0]         packet_sym,
  output logic               err,
  output logic [1:0]         err_code
);
  import h14rx_pkg::*;

  localparam logic [9:0] Ctrl00 = 10'b1101010100;
  localparam logic [9:0] Ctrl01 = 10'b0010101011;
  localparam logic [9:0] Ctrl10 = 10'b0101010100;
  localparam logic [9:0] Ctrl11 = 10'b1010101011;
  localparam logic [9:0] GuardA = 10'b1011001100;
  localparam logic [9:0] GuardB = 10'b0100110011;

  localparam logic [1:0] ErrShortPre = 2'd0;
  localparam logic [1:0] ErrGuardLen = 2'd1;
  localparam logic [1:0] ErrOverrun  = 2'd2;
  localparam logic [1:0] ErrTrunc    = 2'd3;

  typedef enum logic [2:0] {
    StCtrl    = 3'd0,
    StVGuard  = 3'd1,
    StVAct    = 3'd2,
    StDLGuard = 3'd3,
    StDAct    = 3'd4,
    StDTGuard = 3'd5
  } state_t;

  function automatic logic isCtrlTok(input logic [9:0] s);
    return (s == Ctrl00) || (s == Ctrl01) || (s == Ctrl10) || (s == Ctrl11);
  endfunction

  logic isVp, isDp, isVgb, isDgb, allCtrl;

  assign isVp    = (tmds[1] == Ctrl01) && (tmds[2] == Ctrl00);
  assign isDp    = (tmds[1] == Ctrl01) && (tmds[2] == Ctrl01);
  assign isVgb   = (tmds[0] == GuardA) && (tmds[1] == GuardB) && (tmds[2] == GuardA);
  assign isDgb   = (tmds[1] == GuardB) && (tmds[2] == GuardB);
  assign allCtrl = isCtrlTok(tmds[0]) && isCtrlTok(tmds[1]) && isCtrlTok(tmds[2]);

  // Preamble run: length of the current streak and whether it is a DI (vs video) streak.
  logic [3:0] run, runNext;
  logic       runIsDp, runIsDpNext;

  always_comb begin
    runNext     = 4'd0;
    runIsDpNext = runIsDp;
    if (isVp || isDp) begin
      runIsDpNext = isDp;
      if (run == 4'd0 || runIsDp != isDp) begin
        runNext = 4'd1;
      end else if (run != 4'd15) begin
        runNext = run + 4'd1;
      end else begin
        runNext = run;
      end
    end
  end

  logic vpReady, dpReady;
  assign vpReady = !runIsDp && (run >= 4'(MinPreamble));
  assign dpReady =  runIsDp && (run >= 4'(MinPreamble));

  state_t     state, stateNext;
  logic       secondGuard, secondGuardNext;
  logic [4:0] symInc;
  logic       atBoundary, lastPacket;

  assign symInc     = packet_sym + 5'd1;
  assign atBoundary = (symInc == 5'd0);
  assign lastPacket = (packet_idx == 5'(MaxPackets - 1));

  period_t    periodNext;
  logic       errNext, startNext;
  logic [1:0] errCodeNext;
  logic [4:0] idxNext, symNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= StCtrl;
      secondGuard  <= 1'b0;
      run          <= 4'd0;
      runIsDp      <= 1'b0;
      tmds_q       <= '0;
      period       <= Control;
      packet_start <= 1'b0;
      packet_idx   <= 5'd0;
      packet_sym   <= 5'd0;
      err          <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      state        <= stateNext;
      secondGuard  <= secondGuardNext;
      run          <= runNext;
      runIsDp      <= runIsDpNext;
      tmds_q       <= tmds;
      period       <= periodNext;
      packet_start <= startNext;
      packet_idx   <= idxNext;
      packet_sym   <= symNext;
      err          <= errNext;
      err_code     <= errCodeNext;
    end
  end

  // Guard states are entered on the first guard symbol; secondGuard marks that both were seen.
  always_comb begin
    stateNext       = state;
    secondGuardNext = 1'b0;
    case (state)
      StCtrl: begin
        if (isVgb && vpReady) begin
          stateNext = StVGuard;
        end else if (isDgb && dpReady) begin
          stateNext = StDLGuard;
        end
      end
      StVGuard: begin
        if (!secondGuard) begin
          if (isVgb) begin
            secondGuardNext = 1'b1;
          end else begin
            stateNext = StCtrl;
          end
        end else if (isVgb || allCtrl) begin
          stateNext = StCtrl;
        end else begin
          stateNext = StVAct;
        end
      end
      StVAct: begin
        if (allCtrl) begin
          stateNext = StCtrl;
        end
      end
      StDLGuard: begin
        if (!secondGuard) begin
          if (isDgb) begin
            secondGuardNext = 1'b1;
          end else begin
            stateNext = StCtrl;
          end
        end else if (isDgb || allCtrl) begin
          stateNext = StCtrl;
        end else begin
          stateNext = StDAct;
        end
      end
      StDAct: begin
        if (!atBoundary) begin
          if (isDgb || allCtrl) begin
            stateNext = StCtrl;
          end
        end else if (isDgb) begin
          stateNext = StDTGuard;
        end else if (allCtrl || lastPacket) begin
          stateNext = StCtrl;
        end
      end
      StDTGuard: stateNext = StCtrl;
      default:   stateNext = StCtrl;
    endcase
  end

  always_comb begin
    periodNext  = Control;
    errNext     = 1'b0;
    errCodeNext = err_code;
    startNext   = 1'b0;
    idxNext     = packet_idx;
    symNext     = packet_sym;
    case (state)
      StCtrl: begin
        if (isVp) begin
          periodNext = VideoPreamble;
        end else if (isDp) begin
          periodNext = DataIslandPreamble;
        end else if (isVgb) begin
          if (vpReady) begin
            periodNext = VideoGuard;
          end else begin
            errNext     = 1'b1;
            errCodeNext = ErrShortPre;
          end
        end else if (isDgb) begin
          if (dpReady) begin
            periodNext = DataIslandGuard;
          end else begin
            errNext     = 1'b1;
            errCodeNext = ErrShortPre;
          end
        end
      end
      StVGuard: begin
        if (!secondGuard) begin
          if (isVgb) begin
            periodNext = VideoGuard;
          end else begin
            errNext     = 1'b1;
            errCodeNext = ErrGuardLen;
          end
        end else if (isVgb) begin
          errNext     = 1'b1;
          errCodeNext = ErrGuardLen;
        end else if (!allCtrl) begin
          periodNext = VideoActive;
        end
      end
      StVAct: begin
        if (!allCtrl) begin
          periodNext = VideoActive;
        end
      end
      StDLGuard: begin
        if (!secondGuard) begin
          if (isDgb) begin
            periodNext = DataIslandGuard;
          end else begin
            errNext     = 1'b1;
            errCodeNext = ErrGuardLen;
          end
        end else if (isDgb || allCtrl) begin
          errNext     = 1'b1;
          errCodeNext = ErrGuardLen;
        end else begin
          periodNext = DataIslandActive;
          startNext  = 1'b1;
          idxNext    = 5'd0;
          symNext    = 5'd0;
        end
      end
      StDAct: begin
        if (!atBoundary) begin
          if (isDgb || allCtrl) begin
            errNext     = 1'b1;
            errCodeNext = ErrTrunc;
          end else begin
            periodNext = DataIslandActive;
            symNext    = symInc;
          end
        end else if (isDgb) begin
          periodNext = DataIslandGuard;
        end else if (allCtrl) begin
          errNext     = 1'b1;
          errCodeNext = ErrGuardLen;
        end else if (lastPacket) begin
          errNext     = 1'b1;
          errCodeNext = ErrOverrun;
        end else begin
          periodNext = DataIslandActive;
          startNext  = 1'b1;
          idxNext    = packet_idx + 5'd1;
          symNext    = 5'd0;
        end
      end
      StDTGuard: begin
        if (isDgb) begin
          periodNext = DataIslandGuard;
        end else begin
          errNext     = 1'b1;
          errCodeNext = ErrGuardLen;
        end
      end
      default: ;
    endcase
  end

`ifdef H14RX_PERIOD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      err_count    <= 16'd0;
      packet_count <= 16'd0;
    end else begin
      if (errNext && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
      if (startNext && packet_count != 16'hFFFF) begin
        packet_count <= packet_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/h14rx_period_tracker.md
Name: h14rx_period_tracker

Overview:
- Sink-side counterpart of the HDMI 1.4 TX period scheduler.
- Watches the three received 10-bit TMDS channel symbols and classifies each one by period type: Control, Video/DI preamble, Video/DI guard, Video active, or DI active.
- Tracks data-island packet framing: 32 symbols per packet, up to 18 packets.
- Sits after the per-channel word aligner, before the TERC4/video decoders; drives their decode mode and the packet assembler.

Parameters:
- MinPreamble, 8, consecutive identical preamble symbols required before a guard band is accepted (range 1..15).
- MaxPackets, 18, maximum packets per data island; the next packet after this is an overrun.

Ports:
- clk  input  1  pixel/TMDS character clock
- rst_n  input  1  synchronous active-low reset
- tmds  input  [2:0][9:0]  aligned TMDS symbols, ch0..ch2, one per clk
- tmds_q  output  [2:0][9:0]  tmds delayed 1 clk, aligned with the classification outputs
- period  output  h14rx_pkg::period_t  class of tmds_q
- packet_start  output  1  pulse on tmds_q = symbol 0 of a DI packet
- packet_idx  output  [4:0]  packet number within the current island (0..MaxPackets-1)
- packet_sym  output  [4:0]  symbol index within the packet (0..31)
- err  output  1  one-clk pulse on a framing violation
- err_code  output  [1:0]  0 short preamble, 1 bad guard length, 2 packet overrun, 3 truncated packet; held until the next err

Behaviour:
- Token decode (combinational, on tmds):
  - CTRL(v): control tokens, 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
  - VGB: ch0=1011001100, ch1=0100110011, ch2=1011001100.
  - DGB: ch1=ch2=0100110011; ch0 ignored.
  - Video preamble VP: ch1=CTRL(01) and ch2=CTRL(00).
  - DI preamble DP: ch1=CTRL(01) and ch2=CTRL(01).
- Outputs are registered: latency is 1 clk from tmds to all outputs.
- Reset values: period=Control, tmds_q=0, packet_start=0, packet_idx=0, packet_sym=0, err=0, err_code=0, run counter=0, FSM=CTRL.
- Reset dominates every other event; asserting it mid-island returns the block to reset values on the next clk.
- run: 4-bit count of consecutive VP (or consecutive DP) symbols.
  - Saturates at 15.
  - Cleared on a pattern change or any non-preamble symbol.
- FSM states and transitions:
  - CTRL: VP or DP → period=VideoPreamble or DataIslandPreamble, run++.
  - CTRL, VGB with last run of VP ≥ MinPreamble → V_GUARD, guard count=1, period=VideoGuard.
  - CTRL, DGB with last run of DP ≥ MinPreamble → D_LGUARD, period=DataIslandGuard.
  - CTRL, VGB/DGB with a short or absent run → err, code 0, period=Control, stay in CTRL.
  - Any other symbol in CTRL → Control.
  - V_GUARD: needs exactly 2 VGB, then → V_ACT.
    - A non-VGB after 1 guard, or a third VGB → err, code 1, CTRL.
  - V_ACT: period=VideoActive until all three channels carry CTRL tokens; that symbol is Control and the FSM → CTRL.
  - D_LGUARD: needs exactly 2 DGB, then → D_ACT with packet_idx=0, packet_sym=0, packet_start=1.
    - Length violation → err, code 1, CTRL.
  - D_ACT: period=DataIslandActive; packet_sym increments and wraps 31→0.
    - On wrap, packet_idx++ and packet_start=1.
    - DGB or all-CTRL seen while packet_sym≠0 → err, code 3, CTRL; the symbol is classified Control.
    - At packet_sym=0 boundary, DGB → D_TGUARD, period=DataIslandGuard.
    - Boundary after MaxPackets packets without DGB → err, code 2, CTRL.
  - D_TGUARD: needs exactly 2 DGB, then → CTRL.
    - Second symbol not DGB → err, code 1, CTRL.
- packet_idx/packet_sym hold their last value outside D_ACT.
- The run counter keeps counting in CTRL regardless of errors, so resync is immediate.

Optional Feature:
- Macro H14RX_PERIOD_STATS_EN.
- When defined, adds outputs err_count [15:0] and packet_count [15:0].
  - err_count increments on every err.
  - packet_count increments on every packet_start.
  - Both saturate at 16'hFFFF, reset to 0, and clear synchronously on new input stats_clr (1 bit).
- When undefined, these ports and their registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 for 3 clk while driving DGB → period=Control, err=0, packet_idx=0, tmds_q=0.
- Video line: 4 CTRL(00), 8 VP, 2 VGB, 1280 video symbols, all-CTRL → period sequence Control×4, VideoPreamble×8, VideoGuard×2, VideoActive×1280, Control; err never set.
- DI, 2 packets: 8 DP, 2 DGB, 64 TERC4 symbols, 2 DGB, CTRL → packet_start at active symbols 0 and 32; packet_idx 0 then 1; trailing DataIslandGuard×2; then Control.
- Short preamble: 6 DP then DGB (MinPreamble=8) → err=1 with err_code=0 one clk after the DGB; period stays Control.
- Truncated packet: DGB injected at packet_sym=17 → err with err_code=3, period=Control; then a fresh 8 DP + 2 DGB island is tracked correctly.
- Overrun: 19 packets with no trailing guard → err with err_code=2 at the 19th boundary; with H14RX_PERIOD_STATS_EN, packet_count=18 and err_count=1.
